// File: rtl/puzzle_mover.sv
// puzzle_mover: play-stage engine for a 2x2 sliding puzzle.
// Loads a generated board on a start edge, moves the blank on button edges,
// counts legal moves in two BCD digits and flags the solved arrangement.
//
// state  | meaning
// IDLE   | no game loaded yet, waiting for a valid start
// PLAY   | game running, direction events move the blank
// WON    | board solved, board and count frozen until reload
module puzzle_mover #(
    parameter logic [2:0] BLANK    = 3'b100,
    parameter logic [7:0] MOVE_MAX = 8'h99
) (
    input  logic        clk_d,
    input  logic        rst,
    input  logic [11:0] board_in,
    input  logic        start,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    output logic [11:0] board,
    output logic [7:0]  moves,
    output logic        solved,
    output logic        illegal,
    output logic        load_err,
    output logic        playing
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_WON} state_t;

    localparam logic [11:0] EMPTY_BOARD = {BLANK, BLANK, BLANK, BLANK};

    state_t      r_state;
    logic [11:0] r_board;
    logic [7:0]  r_moves;
    logic [1:0]  r_blank_pos;
    logic        r_solved;
    logic        r_illegal;
    logic        r_load_err;
    logic        r_playing;
    logic        r_start_q, r_up_q, r_down_q, r_left_q, r_right_q;

    logic        w_start_ev, w_up_ev, w_down_ev, w_left_ev, w_right_ev;
    logic        w_one_dir;
    logic        w_legal;
    logic [1:0]  w_nbr;
    logic [11:0] w_moved;
    logic [7:0]  w_moves_inc;

    // Cell 0 sits in the top bits; index 3 is bottom-right.
    function automatic logic [2:0] f_cell(input logic [11:0] b, input logic [1:0] idx);
        case (idx)
            2'd0:    return b[11:9];
            2'd1:    return b[8:6];
            2'd2:    return b[5:3];
            default: return b[2:0];
        endcase
    endfunction

    function automatic logic [11:0] f_set(input logic [11:0] b, input logic [1:0] idx,
                                          input logic [2:0] v);
        logic [11:0] r;
        r = b;
        case (idx)
            2'd0:    r[11:9] = v;
            2'd1:    r[8:6]  = v;
            2'd2:    r[5:3]  = v;
            default: r[2:0]  = v;
        endcase
        return r;
    endfunction

    // One blank, three tiles all below BLANK and pairwise distinct.
    function automatic logic f_valid(input logic [11:0] b);
        logic [2:0] c [4];
        int         n_blank;
        logic       ok;
        ok      = 1'b1;
        n_blank = 0;
        for (int i = 0; i < 4; i++) c[i] = f_cell(b, 2'(i));
        for (int i = 0; i < 4; i++) begin
            if (c[i] == BLANK) n_blank++;
            else if (c[i] > 3'b011) ok = 1'b0;
            for (int j = i + 1; j < 4; j++)
                if (c[i] != BLANK && c[i] == c[j]) ok = 1'b0;
        end
        return ok && (n_blank == 1);
    endfunction

    function automatic logic [1:0] f_blank_pos(input logic [11:0] b);
        logic [1:0] p;
        p = 2'd0;
        for (int i = 0; i < 4; i++)
            if (f_cell(b, 2'(i)) == BLANK) p = 2'(i);
        return p;
    endfunction

    function automatic logic f_is_solved(input logic [11:0] b);
        return (b[2:0] == BLANK) && (b[11:9] < b[8:6]) && (b[8:6] < b[5:3]);
    endfunction

    // Rising-edge events from the registered input history.
    always_comb begin
        w_start_ev = start & ~r_start_q;
        w_up_ev    = up    & ~r_up_q;
        w_down_ev  = down  & ~r_down_q;
        w_left_ev  = left  & ~r_left_q;
        w_right_ev = right & ~r_right_q;
        w_one_dir  = $onehot({w_up_ev, w_down_ev, w_left_ev, w_right_ev});
    end

    // Neighbour of the blank in the requested direction and the board after the swap.
    always_comb begin
        w_legal = 1'b0;
        w_nbr   = r_blank_pos;
        if (w_up_ev) begin
            w_legal = r_blank_pos[1];
            w_nbr   = {1'b0, r_blank_pos[0]};
        end else if (w_down_ev) begin
            w_legal = ~r_blank_pos[1];
            w_nbr   = {1'b1, r_blank_pos[0]};
        end else if (w_left_ev) begin
            w_legal = r_blank_pos[0];
            w_nbr   = {r_blank_pos[1], 1'b0};
        end else if (w_right_ev) begin
            w_legal = ~r_blank_pos[0];
            w_nbr   = {r_blank_pos[1], 1'b1};
        end
        w_moved = f_set(f_set(r_board, r_blank_pos, f_cell(r_board, w_nbr)), w_nbr, BLANK);
    end

    // Two-digit BCD increment that sticks at the maximum.
    always_comb begin
        w_moves_inc = r_moves;
        if (r_moves != MOVE_MAX) begin
            if (r_moves[3:0] == 4'd9) w_moves_inc = {r_moves[7:4] + 4'd1, 4'd0};
            else                      w_moves_inc = {r_moves[7:4], r_moves[3:0] + 4'd1};
        end
    end

    // Game FSM: loads, moves, win detection and registered status outputs.
    always_ff @(posedge clk_d or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_board     <= EMPTY_BOARD;
            r_moves     <= 8'h00;
            r_blank_pos <= 2'd0;
            r_solved    <= 1'b0;
            r_illegal   <= 1'b0;
            r_load_err  <= 1'b0;
            r_playing   <= 1'b0;
            r_start_q   <= 1'b0;
            r_up_q      <= 1'b0;
            r_down_q    <= 1'b0;
            r_left_q    <= 1'b0;
            r_right_q   <= 1'b0;
        end else begin
            r_start_q  <= start;
            r_up_q     <= up;
            r_down_q   <= down;
            r_left_q   <= left;
            r_right_q  <= right;
            r_illegal  <= 1'b0;
            r_load_err <= 1'b0;
            if (w_start_ev) begin
                // A start edge wins over any direction in the same cycle.
                if (f_valid(board_in)) begin
                    r_board     <= board_in;
                    r_blank_pos <= f_blank_pos(board_in);
                    r_moves     <= 8'h00;
                    r_state     <= S_PLAY;
                    r_playing   <= 1'b1;
                    r_solved    <= 1'b0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_PLAY: begin
                        if (f_is_solved(r_board)) begin
                            r_state   <= S_WON;
                            r_playing <= 1'b0;
                            r_solved  <= 1'b1;
                        end else if (w_one_dir) begin
                            if (w_legal) begin
                                r_board     <= w_moved;
                                r_blank_pos <= w_nbr;
                                r_moves     <= w_moves_inc;
                            end else begin
                                r_illegal <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign board    = r_board;
    assign moves    = r_moves;
    assign solved   = r_solved;
    assign illegal  = r_illegal;
    assign load_err = r_load_err;
    assign playing  = r_playing;

endmodule
